// File: rtl/keyschedule_reverse.sv
// Reverse AES-128 key schedule: starting from round key 10, emits round keys
// 10 down to 0 over a valid/ready stream, then pulses done.
module keyschedule_reverse (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         rk_valid,
   output logic         busy,
   output logic         done,
   output logic [1:0]   dbg_state
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EMIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [1:0]   r_state;
   logic [127:0] r_round_key;
   logic [3:0]   r_round_idx;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3;
   logic [31:0]  w_p0, w_p1, w_p2, w_p3;
   logic [31:0]  w_rot, w_sub;
   logic [7:0]   w_rcon;
   logic         w_xfer;

   // Handshake: rk_valid is high for the whole EMIT state; a key transfers on any
   // cycle with rk_valid & rk_ready, and round_key/round_idx change only on a transfer.
   assign rk_valid  = (r_state == EMIT);
   assign busy      = (r_state == EMIT);
   assign done      = (r_state == DONE);
   assign dbg_state = r_state;
   assign round_key = r_round_key;
   assign round_idx = r_round_idx;
   assign w_xfer    = rk_valid & rk_ready;

   assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;
   assign w_p3  = w_w3 ^ w_w2;
   assign w_p2  = w_w2 ^ w_w1;
   assign w_p1  = w_w1 ^ w_w0;
   assign w_rot = {w_p3[23:0], w_p3[31:24]};
   assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
   assign w_p0  = w_w0 ^ w_sub ^ {w_rcon, 24'h0};

   always_comb begin
      w_rcon = 8'h00;
      case (r_round_idx)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_round_key <= 128'h0;
         r_round_idx <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_round_key <= key_in;
                  r_round_idx <= 4'd10;
                  r_state     <= EMIT;
               end
            end
            EMIT: begin
               if (w_xfer) begin
                  if (r_round_idx == 4'd0) begin
                     r_state <= DONE;
                  end else begin
                     r_round_key <= {w_p0, w_p1, w_p2, w_p3};
                     r_round_idx <= r_round_idx - 4'd1;
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_keyschedule_reverse.sv
// Scoreboard bench for keyschedule_reverse: a forward AES-128 expansion model fills
// the expected queue, a negedge monitor pops and compares each transferred key.
module tb_keyschedule_reverse;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key_in = 128'h0;
   logic         rk_ready = 1'b1;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         rk_valid;
   logic         busy;
   logic         done;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   keyschedule_reverse dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_in    (key_in),
      .rk_ready  (rk_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .rk_valid  (rk_valid),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   logic [0:255][7:0] sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   int            n_checks = 0;
   int            n_pass = 0;
   int            n_done = 0;
   logic [131:0]  exp_q[$];
   logic [127:0]  seen_key[0:10];
   logic [127:0]  ks[0:10];
   logic          ready_rand = 1'b0;
   logic          stall_pending = 1'b0;
   logic [131:0]  stall_val = '0;

   task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Forward expansion from the cipher key; fills ks[0..10].
   task automatic expand(input logic [127:0] ck);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rc;
      rc = 8'h01;
      ks[0] = ck;
      for (int r = 1; r <= 10; r++) begin
         {w0, w1, w2, w3} = ks[r-1];
         t = {sbox_tbl[w3[23:16]], sbox_tbl[w3[15:8]], sbox_tbl[w3[7:0]], sbox_tbl[w3[31:24]]};
         t = t ^ {rc, 24'h0};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         ks[r] = {w0, w1, w2, w3};
         rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
   endtask

   task automatic push_sched();
      for (int i = 10; i >= 0; i--) exp_q.push_back({4'(i), ks[i]});
   endtask

   task automatic issue_start(input logic [127:0] k);
      start = 1'b1;
      key_in = k;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int c;
      c = 0;
      while (!done && c < limit) begin
         tick();
         c++;
      end
      check("done_seen", {139'h0, done}, 140'h1);
   endtask

   task automatic wait_idx(input logic [3:0] idx);
      int c;
      c = 0;
      while (!(rk_valid && round_idx == idx) && c < 50) begin
         tick();
         c++;
      end
      check("reach_idx", {135'h0, rk_valid, round_idx}, {135'h0, 1'b1, idx});
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rk_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor: pops one expected entry per transfer and checks stability across stalls.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && done) n_done++;
         if (rst_n && rk_valid) begin
            if (stall_pending) check("stall_hold", {8'h0, round_idx, round_key}, {8'h0, stall_val});
            if (rk_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL extra_key: got idx %0d key %h with no expected entry", round_idx, round_key);
               end else begin
                  check("key_seq", {8'h0, round_idx, round_key}, {8'h0, exp_q.pop_front()});
               end
               if (round_idx <= 4'd10) seen_key[round_idx] = round_key;
               stall_pending = 1'b0;
            end else begin
               stall_pending = 1'b1;
               stall_val = {round_idx, round_key};
            end
         end else begin
            stall_pending = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [127:0] other;
      #3;
      check("reset_outputs", {1'b0, round_key, round_idx, rk_valid, busy, done, dbg_state}, 140'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // FIPS-197 A.1 vector, ready held high, cycle-exact timing
      for (int i = 0; i <= 10; i++) seen_key[i] = 128'h0;
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
      push_sched();
      check("idle_before_start", {139'h0, rk_valid}, 140'h0);
      issue_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("valid_rise", {134'h0, rk_valid, busy, round_idx}, {134'h0, 1'b1, 1'b1, 4'd10});
      c = 1;
      while (!done && c < 40) begin
         tick();
         c++;
      end
      check("done_cycle", 140'(c), 140'd12);
      check("done_no_valid", {139'h0, rk_valid}, 140'h0);
      tick();
      check("done_one_cycle", {137'h0, done, dbg_state}, 140'h0);
      check("fips_idx10", {12'h0, seen_key[10]}, {12'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
      check("fips_idx9",  {12'h0, seen_key[9]},  {12'h0, 128'hac7766f319fadc2128d12941575c006e});
      check("fips_idx1",  {12'h0, seen_key[1]},  {12'h0, 128'ha0fafe1788542cb123a339392a6c7605});
      check("fips_idx0",  {12'h0, seen_key[0]},  {12'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c});
      check("fips_queue_empty", 140'(exp_q.size()), 140'h0);

      // Backpressure with the same vector
      push_sched();
      ready_rand = 1'b1;
      issue_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_done(300);
      ready_rand = 1'b0;
      tick();
      check("bp_queue_empty", 140'(exp_q.size()), 140'h0);

      // Start pulsed while busy is ignored
      expand({$urandom, $urandom, $urandom, $urandom});
      push_sched();
      other = {$urandom, $urandom, $urandom, $urandom};
      issue_start(ks[10]);
      wait_idx(4'd5);
      check("busy_mid", {139'h0, busy}, 140'h1);
      issue_start(other);
      wait_done(40);
      tick();
      tick();
      tick();
      check("no_restart", {138'h0, rk_valid, busy}, 140'h0);
      check("busy_queue_empty", 140'(exp_q.size()), 140'h0);

      // Asynchronous reset at idx 6
      expand(128'h000102030405060708090a0b0c0d0e0f);
      push_sched();
      issue_start(ks[10]);
      wait_idx(4'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {1'b0, round_key, round_idx, rk_valid, busy, done, dbg_state}, 140'h0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("idle_after_reset", {136'h0, rk_valid, done, dbg_state}, 140'h0);
      push_sched();
      issue_start(ks[10]);
      wait_done(40);
      tick();
      check("reset_queue_empty", 140'(exp_q.size()), 140'h0);

      // Back-to-back with start held high
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
      push_sched();
      other = ks[10];
      expand(128'h3243f6a8885a308d313198a2e0370734);
      push_sched();
      start = 1'b1;
      key_in = other;
      tick();
      key_in = ks[10];
      wait_done(40);
      tick();
      check("b2b_idle_gap", {137'h0, rk_valid, dbg_state}, 140'h0);
      tick();
      check("b2b_valid_rise", {135'h0, rk_valid, round_idx}, {135'h0, 1'b1, 4'd10});
      start = 1'b0;
      wait_done(40);
      tick();
      check("b2b_queue_empty", 140'(exp_q.size()), 140'h0);

      // Round trip over random cipher keys
      for (int n = 0; n < 1000; n++) begin
         expand({$urandom, $urandom, $urandom, $urandom});
         push_sched();
         ready_rand = (n % 4 == 3);
         issue_start(ks[10]);
         wait_done(300);
         ready_rand = 1'b0;
         tick();
      end
      check("rt_queue_empty", 140'(exp_q.size()), 140'h0);
      check("done_count", 140'(n_done), 140'd1006);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/keyschedule_reverse.md
KEYSCHEDULE_REVERSE -- requirements
Module: keyschedule_reverse

Interface
REQ-001 No parameters; the block is fixed to AES-128 (128-bit key, 10 rounds).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a reverse schedule; sampled only in IDLE.
REQ-005 key_in  input  128  round-10 key (last forward round key); w0 at [127:96], w3 at [31:0]; sampled on the accepted start.
REQ-006 rk_ready  input  1  consumer accepts the current round key.
REQ-007 round_key  output  128  current round key, same word order as key_in.
REQ-008 round_idx  output  4  round number of round_key, 10 down to 0.
REQ-009 rk_valid  output  1  round_key and round_idx are valid.
REQ-010 busy  output  1  high in EMIT state.
REQ-011 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-012 The FSM SHALL have three states: IDLE, EMIT and DONE.
REQ-013 IDLE: when start=1, the block SHALL register key_in into round_key, load round_idx=10 and move to EMIT.
REQ-014 rk_valid SHALL equal (state==EMIT) and SHALL rise exactly one cycle after the accepted start.
REQ-015 Handshake: a transfer occurs on a cycle with rk_valid=1 and rk_ready=1; while rk_ready=0, round_key and round_idx SHALL hold stable.
REQ-016 On a transfer with round_idx=i>0, the next cycle SHALL present K(i-1) with round_idx=i-1; throughput is one key per cycle when rk_ready is held high.
REQ-017 Inverse step, from K(i)=w0..w3: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^{Rcon(i),24'h0}.
REQ-018 RotWord SHALL be a 1-byte left rotate ({b1,b2,b3,b0}); SubWord SHALL apply the forward AES S-box to each of the 4 bytes.
REQ-019 Rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex), selected by the current round_idx; other indices are unreachable.
REQ-020 On a transfer with round_idx=0, the FSM SHALL go to DONE; DONE SHALL assert done for one cycle, with rk_valid=0, then return to IDLE.
REQ-021 start SHALL be ignored in EMIT and DONE; no restart or abort is available except reset.
REQ-022 start and done may coincide only in the DONE cycle, and that start SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-023 A full schedule with rk_ready held high SHALL take 11 valid cycles plus 1 done cycle after start (13 cycles start-to-IDLE).
REQ-024 round_key SHALL hold its last value in IDLE and DONE; consumers SHALL use it only while rk_valid=1.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously force: state=IDLE, round_key=0, round_idx=0, rk_valid=0, busy=0, done=0.
REQ-026 Reset asserted mid-EMIT SHALL abort the schedule with no further rk_valid or done; after release, the block SHALL wait for a new start.

Verification
REQ-027 FIPS-197 A.1 (cipher key 2b7e151628aed2a6abf7158809cf4f3c): start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 and rk_ready=1 -> idx10 = key_in; idx9 = ac7766f319fadc2128d12941575c006e; idx1 = a0fafe1788542cb123a339392a6c7605; idx0 = 2b7e151628aed2a6abf7158809cf4f3c; done at cycle 12 after start.
REQ-028 Backpressure: same vector, with rk_ready toggling pseudo-randomly -> identical 11-key sequence, with no key skipped or repeated and data stable during stalls.
REQ-029 Start during busy: pulse start with a different key_in at idx 5 -> the sequence is unaffected and no restart occurs.
REQ-030 Reset at idx 6 -> all outputs are 0 immediately (asynchronous); after release and a new start, the sequence is correct from idx 10.
REQ-031 Back-to-back: start held high continuously -> the second schedule begins in the IDLE cycle after done, with rk_valid rising the following cycle.
REQ-032 Round-trip: random cipher key -> the bench model's forward expansion matches all 11 keys emitted in reverse, over at least 1000 keys.
